// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the RV32I pipeline.
//   XLEN             - architectural register / address width
//   NOP_INST         - canonical NOP (addi x0, x0, 0) shown when no instruction is valid
//   RESET_PC_DEFAULT - default first fetch address after reset
//   fetch_entry_t    - {pc, inst} pair carried by fetch-side buffers
//   word_align()     - clears the byte-offset bits of an address
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Instruction fetch is word-granular, so the low two address bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: synchronous FIFO used as the fetch instruction buffer.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push       - write push_data (ignored when full or flushing)
//   push_data  - entry to write
//   pop        - drop the head entry (ignored when empty or flushing)
//   flush      - empty the FIFO; wins over push and pop
//   head_data  - oldest entry (undefined content when empty)
//   count      - number of valid entries (0..DEPTH)
//   empty      - count == 0
module inst_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [AW:0]      count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against occupancy and flush.
  always_comb begin
    do_push_s = push & ~flush & (count_r != (AW+1)'(DEPTH));
    do_pop_s  = pop  & ~flush & (count_r != {(AW+1){1'b0}});
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign empty     = (count_r == {(AW+1){1'b0}});

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage RV32I pipeline.
// Issues word fetches over a req/gnt/rvalid handshake, buffers returned
// instructions with their PCs in inst_fifo and presents them downstream
// with a valid/ready handshake. Execute-stage redirects flush the buffer
// and discard responses of the old stream that are still in flight.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   if_mem_req_o / if_mem_addr_o  - fetch request and word address
//   mem_if_gnt_i                  - request accepted this cycle
//   mem_if_rvalid_i / _rdata_i    - in-order response and instruction word
//   ex_redirect_i / _pc_i         - redirect fetch to a new target
//   id_ready_i                    - downstream accepts the presented instruction
//   if_valid_o / if_pc_o / if_inst_o - presented instruction (0 / NOP when empty)
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            if_mem_req_o,
  output logic [XLEN-1:0] if_mem_addr_o,
  input  logic            mem_if_gnt_i,
  input  logic            mem_if_rvalid_i,
  input  logic [XLEN-1:0] mem_if_rdata_i,
  input  logic            ex_redirect_i,
  input  logic [XLEN-1:0] ex_redirect_pc_i,
  input  logic            id_ready_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_inst_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] resp_pc_r;
  logic [CW-1:0]   outstanding_r;
  logic [CW-1:0]   drop_r;

  logic [CW-1:0]   count_s;
  logic            empty_s;
  fetch_entry_t    head_s;
  fetch_entry_t    push_entry_s;
  logic            pop_s;
  logic            push_s;
  logic            grant_s;
  logic            credit_s;
  logic [CW:0]     occupancy_s;

  // Handshake decode. Credit counts buffered plus in-flight fetches so a
  // returning response always finds room; the pop of this cycle is credited
  // early to sustain one instruction per cycle with a two-entry buffer.
  always_comb begin
    pop_s        = if_valid_o & id_ready_i & ~ex_redirect_i;
    occupancy_s  = {1'b0, count_s} + {1'b0, outstanding_r} - (CW+1)'(pop_s);
    credit_s     = (occupancy_s < (CW+1)'(FIFO_DEPTH));
    if_mem_req_o = ~rst & credit_s & ~ex_redirect_i;
    grant_s      = if_mem_req_o & mem_if_gnt_i;
    push_s       = mem_if_rvalid_i & ~ex_redirect_i & ~rst & (drop_r == {CW{1'b0}});
    push_entry_s = '{pc: resp_pc_r, inst: mem_if_rdata_i};
  end

  assign if_mem_addr_o = fetch_pc_r;

  // Fetch/response PC tracking, in-flight count and stale-response drop count.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      drop_r        <= {CW{1'b0}};
    end else if (ex_redirect_i) begin
      // Everything still in flight belongs to the old stream.
      fetch_pc_r    <= word_align(ex_redirect_pc_i);
      resp_pc_r     <= word_align(ex_redirect_pc_i);
      outstanding_r <= outstanding_r - CW'(mem_if_rvalid_i);
      drop_r        <= outstanding_r - CW'(mem_if_rvalid_i);
    end else begin
      if (grant_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
      outstanding_r <= outstanding_r + CW'(grant_s) - CW'(mem_if_rvalid_i);
      if (mem_if_rvalid_i) begin
        if (drop_r != {CW{1'b0}}) begin
          drop_r <= drop_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
          resp_pc_r <= resp_pc_r + 32'd4;
        end
      end
    end
  end

  inst_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (ex_redirect_i),
    .head_data (head_s),
    .count     (count_s),
    .empty     (empty_s)
  );

  // Present the buffer head; an empty buffer shows PC 0 and a NOP.
  always_comb begin
    if_valid_o = ~empty_s;
    if (empty_s) begin
      if_pc_o   = {XLEN{1'b0}};
      if_inst_o = NOP_INST;
    end else begin
      if_pc_o   = head_s.pc;
      if_inst_o = head_s.inst;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req;
  logic [31:0] addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        redir = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic        ready = 1'b0;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_mem_req_o     (req),
    .if_mem_addr_o    (addr),
    .mem_if_gnt_i     (gnt),
    .mem_if_rvalid_i  (rvalid),
    .mem_if_rdata_i   (rdata),
    .ex_redirect_i    (redir),
    .ex_redirect_pc_i (rpc),
    .id_ready_i       (ready),
    .if_valid_o       (valid),
    .if_pc_o          (pc),
    .if_inst_o        (inst)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } item_t;
  typedef struct { logic [31:0] a; int unsigned c; } pend_t;

  item_t exp_q[$];   // instructions that must be delivered next, in order
  pend_t pend_q[$];  // memory model: granted fetches awaiting a response
  item_t mon_e;

  int checks = 0;
  int failures = 0;

  int p_gnt, p_rv, p_ready, p_redir;
  logic do_rst = 1'b1;
  logic fix_tgt_en = 1'b0;
  logic [31:0] fix_tgt = 32'h0;
  int unsigned cyc = 0;
  logic [31:0] exp_fetch = 32'h0;
  logic prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'h0000_0013;
  endfunction

  function automatic bit roll(input int p);
    return ($urandom_range(99) < p);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs after the edge, then record the handshake at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rst   = do_rst;
    gnt   = roll(p_gnt);
    ready = roll(p_ready);
    redir = !do_rst && roll(p_redir);
    if (fix_tgt_en) rpc = fix_tgt;
    else if (roll(25)) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
    else rpc = 32'($urandom);
    if (!do_rst && pend_q.size() > 0 && pend_q[0].c < cyc && roll(p_rv)) begin
      rvalid = 1'b1;
      rdata  = mem_word(pend_q[0].a);
    end else begin
      rvalid = 1'b0;
      rdata  = 32'($urandom);
    end
    @(negedge clk);
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      exp_fetch = 32'h0000_0000;
      prev_wait = 1'b0;
    end else begin
      if (rvalid) void'(pend_q.pop_front());
      if (redir) check("redirect_req_low", 32'(req), 32'h0);
      if (prev_wait && !redir) begin
        check("req_hold", 32'(req), 32'h1);
        check("addr_hold", addr, prev_addr);
      end
      if (req && gnt) begin
        check("grant_addr", addr, exp_fetch);
        pend_q.push_back('{a: addr, c: cyc});
        exp_q.push_back('{pc: addr, inst: mem_word(addr)});
        exp_fetch = exp_fetch + 32'd4;
      end
      if (redir) begin
        exp_q.delete();
        exp_fetch = {rpc[31:2], 2'b00};
      end
      prev_wait = req && !gnt && !redir;
      prev_addr = addr;
    end
  endtask

  // Monitor: every accepted instruction must be the next expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (valid && ready && !redir) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_delivery: got pc %h inst %h, expected none", pc, inst);
          end else begin
            mon_e = exp_q.pop_front();
            check("deliver_pc", pc, mon_e.pc);
            check("deliver_inst", inst, mon_e.inst);
          end
        end else if (!valid) begin
          check("idle_pc", pc, 32'h0);
          check("idle_inst", inst, NOP_INST);
        end
      end
    end
  end

  initial begin
    p_gnt = 100; p_rv = 100; p_ready = 100; p_redir = 0;
    do_rst = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, 32'h13);
    check("rst_req", 32'(req), 32'h0);
    do_rst = 1'b0;

    // 1: zero-wait memory, latency and full throughput
    tick(); check("t1_req0", 32'(req), 32'h1); check("t1_addr0", addr, 32'h0);
    tick(); check("t1_addr1", addr, 32'h4);
    tick(); check("t1_first_valid", 32'(valid), 32'h1);
    check("t1_first_pc", pc, 32'h0); check("t1_first_inst", inst, 32'h13);
    tick(); check("t1_second_valid", 32'(valid), 32'h1); check("t1_second_pc", pc, 32'h4);

    // 2: downstream stall with head pc 0x8
    p_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_pc", pc, 32'h8);
      check("t2_hold_inst", inst, 32'h1B);
      check("t2_req_low", 32'(req), 32'h0);
    end
    p_ready = 100;
    tick();
    check("t2_release_pc", pc, 32'h8);
    check("t2_release_req", 32'(req), 32'h1);
    check("t2_release_addr", addr, 32'h10);

    // 3: redirect to 0x100 while the 0x10 fetch is in flight
    p_rv = 0; p_redir = 100; fix_tgt_en = 1'b1; fix_tgt = 32'h100;
    tick();
    p_rv = 100; p_redir = 0; fix_tgt_en = 1'b0;
    tick();
    check("t3_flushed", 32'(valid), 32'h0);
    check("t3_req", 32'(req), 32'h1);
    check("t3_addr", addr, 32'h100);
    tick();
    tick();
    check("t3_new_valid", 32'(valid), 32'h1);
    check("t3_new_pc", pc, 32'h100);

    // 4: redirect coinciding with rvalid and id_ready
    p_redir = 100; fix_tgt_en = 1'b1; fix_tgt = 32'h203;
    tick();
    p_redir = 0; fix_tgt_en = 1'b0;
    tick();
    check("t4_valid", 32'(valid), 32'h0);
    check("t4_req", 32'(req), 32'h1);
    check("t4_addr", addr, 32'h200);
    repeat (4) tick();

    // 5: grant withheld for three cycles on address 0x4
    do_rst = 1'b1; tick(); do_rst = 1'b0;
    tick(); check("t5_addr0", addr, 32'h0);
    p_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_req_stall", 32'(req), 32'h1);
      check("t5_addr_stall", addr, 32'h4);
    end
    p_gnt = 100;
    tick(); check("t5_addr_grant", addr, 32'h4);
    tick(); check("t5_addr_next", addr, 32'h8);

    // 6: reset with two entries buffered
    p_ready = 0;
    repeat (4) tick();
    check("t6_buffered", 32'(valid), 32'h1);
    do_rst = 1'b1; tick(); do_rst = 1'b0;
    tick();
    check("t6_valid", 32'(valid), 32'h0);
    check("t6_inst", inst, 32'h13);
    check("t6_pc", pc, 32'h0);
    check("t6_req", 32'(req), 32'h1);
    check("t6_addr", addr, 32'h0);
    p_ready = 100;

    // Random traffic with redirects, stalls and variable memory latency
    for (int blk = 0; blk < 15; blk++) begin
      p_gnt   = 30 + int'($urandom_range(70));
      p_rv    = 30 + int'($urandom_range(70));
      p_ready = 30 + int'($urandom_range(70));
      p_redir = int'($urandom_range(8));
      repeat (200) tick();
    end

    // Drain: everything granted since the last redirect must come out
    p_gnt = 0; p_rv = 100; p_ready = 100; p_redir = 0;
    repeat (30) tick();
    check("drain_expected_empty", 32'(exp_q.size()), 32'h0);
    check("drain_mem_idle", 32'(pend_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
